// File: rtl/uart_host_tx_pkg.sv
// Shared definitions for the host-side UART transmitter: FSM encodings, parity modes
// and the baud divider computation, kept in one place so the matching receiver can reuse them.
package uart_host_tx_pkg;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_START  = 3'd1;
  localparam logic [2:0] ST_DATA   = 3'd2;
  localparam logic [2:0] ST_PARITY = 3'd3;
  localparam logic [2:0] ST_STOP   = 3'd4;

  localparam int PARITY_NONE = 0;
  localparam int PARITY_EVEN = 1;
  localparam int PARITY_ODD  = 2;

  // Cycles per bit; truncating division, caller must keep the result >= 2.
  function automatic int baud_div(input int clk_hz, input int baud);
    return clk_hz / baud;
  endfunction

  function automatic logic parity_bit(input logic [7:0] b, input int mode);
    return (mode == PARITY_ODD) ? ~^b : ^b;
  endfunction

endpackage

// File: rtl/uart_host_tx_if.sv
// Write-side bus of the UART transmitter: byte push handshake plus FIFO status flags.
interface uart_host_tx_if;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       full;
  logic       empty;
  logic       overflow;

  modport master (output wr_en, output wr_data, input full, input empty, input overflow);
  modport slave  (input wr_en, input wr_data, output full, output empty, output overflow);
endinterface

// File: rtl/uart_tx_fifo.sv
// Single-clock byte FIFO with registered full/empty flags and an overflow pulse.
// The head is read combinationally so the transmitter can load it in the same cycle it pops.
module uart_tx_fifo #(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       push_i,
  input  logic [7:0] push_data_i,
  input  logic       pop_i,
  output logic [7:0] head_o,
  output logic       full_o,
  output logic       empty_o,
  output logic       overflow_o
);
  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL_CNT = {1'b1, {DEPTH_LOG2{1'b0}}};

  logic [7:0]            mem_q [DEPTH];
  logic [DEPTH_LOG2-1:0] wptr_q, rptr_q;
  logic [DEPTH_LOG2:0]   count_q, count_d;
  logic                  full_q, empty_q, overflow_q;
  logic                  push_ok, pop_ok;

  // full_q is the pre-edge flag, so a push while full is dropped even if a pop happens too.
  assign push_ok = push_i && !full_q;
  assign pop_ok  = pop_i && !empty_q;

  always_comb begin
    count_d = count_q;
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wptr_q] <= push_data_i;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q     <= '0;
      rptr_q     <= '0;
      count_q    <= '0;
      full_q     <= 1'b0;
      empty_q    <= 1'b1;
      overflow_q <= 1'b0;
    end else begin
      if (push_ok) wptr_q <= wptr_q + 1'b1;
      if (pop_ok)  rptr_q <= rptr_q + 1'b1;
      count_q    <= count_d;
      full_q     <= (count_d == FULL_CNT);
      empty_q    <= (count_d == '0);
      overflow_q <= push_i && full_q;
    end
  end

  assign head_o     = mem_q[rptr_q];
  assign full_o     = full_q;
  assign empty_o    = empty_q;
  assign overflow_o = overflow_q;
endmodule

// File: rtl/uart_host_tx.sv
// Buffered 8-N-1 UART transmitter (optional parity) driving a registered serial line.
// Back-to-back frames are sent with no idle gap while the FIFO holds data.
module uart_host_tx
  import uart_host_tx_pkg::*;
#(
  parameter int SYS_CLK_FREQ    = 100_000_000,
  parameter int BAUD_RATE       = 115200,
  parameter int FIFO_DEPTH_LOG2 = 4,
  parameter int PARITY_MODE     = 0
) (
  input  logic           clk,
  input  logic           rst,
  uart_host_tx_if.slave  wr_if,
  output logic           busy,
  output logic           tx
);
  localparam int BAUD_DIV = baud_div(SYS_CLK_FREQ, BAUD_RATE);
  localparam int CW       = $clog2(BAUD_DIV);
  localparam logic [CW-1:0] BAUD_LAST = CW'(BAUD_DIV - 1);

  logic [2:0]    state_q, state_d;
  logic [CW-1:0] baud_cnt_q, baud_cnt_d;
  logic [2:0]    bit_idx_q, bit_idx_d;
  logic [7:0]    shift_q, shift_d;
  logic          parity_q, parity_d;
  logic          tx_q, tx_d;
  logic          pop, baud_end, fifo_empty;
  logic [7:0]    head;

  uart_tx_fifo #(.DEPTH_LOG2(FIFO_DEPTH_LOG2)) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (wr_if.wr_en),
    .push_data_i (wr_if.wr_data),
    .pop_i       (pop),
    .head_o      (head),
    .full_o      (wr_if.full),
    .empty_o     (fifo_empty),
    .overflow_o  (wr_if.overflow)
  );

  assign wr_if.empty = fifo_empty;
  assign baud_end    = (baud_cnt_q == BAUD_LAST);

  always_comb begin
    state_d    = state_q;
    baud_cnt_d = baud_cnt_q + 1'b1;
    bit_idx_d  = bit_idx_q;
    shift_d    = shift_q;
    parity_d   = parity_q;
    pop        = 1'b0;
    case (state_q)
      ST_IDLE: begin
        baud_cnt_d = '0;
        if (!fifo_empty) begin
          pop       = 1'b1;
          shift_d   = head;
          parity_d  = parity_bit(head, PARITY_MODE);
          bit_idx_d = '0;
          state_d   = ST_START;
        end
      end
      ST_START: begin
        if (baud_end) begin
          baud_cnt_d = '0;
          bit_idx_d  = '0;
          state_d    = ST_DATA;
        end
      end
      ST_DATA: begin
        if (baud_end) begin
          baud_cnt_d = '0;
          shift_d    = shift_q >> 1;
          if (bit_idx_q == 3'd7) state_d = (PARITY_MODE != PARITY_NONE) ? ST_PARITY : ST_STOP;
          else                   bit_idx_d = bit_idx_q + 1'b1;
        end
      end
      ST_PARITY: begin
        if (baud_end) begin
          baud_cnt_d = '0;
          state_d    = ST_STOP;
        end
      end
      ST_STOP: begin
        if (baud_end) begin
          baud_cnt_d = '0;
          // Chain straight into the next start bit when more data is queued.
          if (!fifo_empty) begin
            pop       = 1'b1;
            shift_d   = head;
            parity_d  = parity_bit(head, PARITY_MODE);
            bit_idx_d = '0;
            state_d   = ST_START;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: begin
        baud_cnt_d = '0;
        state_d    = ST_IDLE;
      end
    endcase
  end

  // Line level follows the current state one cycle later, keeping the pin purely registered.
  always_comb begin
    case (state_q)
      ST_START:  tx_d = 1'b0;
      ST_DATA:   tx_d = shift_q[0];
      ST_PARITY: tx_d = parity_q;
      default:   tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      baud_cnt_q <= '0;
      bit_idx_q  <= '0;
      shift_q    <= '0;
      parity_q   <= 1'b0;
      tx_q       <= 1'b1;
    end else begin
      state_q    <= state_d;
      baud_cnt_q <= baud_cnt_d;
      bit_idx_q  <= bit_idx_d;
      shift_q    <= shift_d;
      parity_q   <= parity_d;
      tx_q       <= tx_d;
    end
  end

  assign busy = (state_q != ST_IDLE);
  assign tx   = tx_q;
endmodule

// File: tb/tb_uart_host_tx.sv
// Directed bench for uart_host_tx: three instances (no/even/odd parity) at BAUD_DIV=16, depth 4.
module tb_uart_host_tx;
  localparam int BD = 16;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  uart_host_tx_if if0 ();
  uart_host_tx_if if1 ();
  uart_host_tx_if if2 ();
  logic busy0, busy1, busy2, tx0, tx1, tx2;

  uart_host_tx #(.SYS_CLK_FREQ(16), .BAUD_RATE(1), .FIFO_DEPTH_LOG2(2), .PARITY_MODE(0)) dut0 (
    .clk(clk), .rst(rst), .wr_if(if0), .busy(busy0), .tx(tx0));
  uart_host_tx #(.SYS_CLK_FREQ(16), .BAUD_RATE(1), .FIFO_DEPTH_LOG2(2), .PARITY_MODE(1)) dut1 (
    .clk(clk), .rst(rst), .wr_if(if1), .busy(busy1), .tx(tx1));
  uart_host_tx #(.SYS_CLK_FREQ(16), .BAUD_RATE(1), .FIFO_DEPTH_LOG2(2), .PARITY_MODE(2)) dut2 (
    .clk(clk), .rst(rst), .wr_if(if2), .busy(busy2), .tx(tx2));

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // exp_line bit i is the i-th line level of the frame (start first, stop last)
  typedef struct {
    int          sel;
    logic [7:0]  data;
    int          nbits;
    logic [10:0] exp_line;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end else begin
      $display("ok   %s: %0h", name, act);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_wr(input int sel, input logic en, input logic [7:0] d);
    case (sel)
      0:       begin if0.wr_en = en; if0.wr_data = d; end
      1:       begin if1.wr_en = en; if1.wr_data = d; end
      default: begin if2.wr_en = en; if2.wr_data = d; end
    endcase
  endtask

  function automatic logic tx_of(input int sel);
    return (sel == 0) ? tx0 : ((sel == 1) ? tx1 : tx2);
  endfunction

  function automatic logic busy_of(input int sel);
    return (sel == 0) ? busy0 : ((sel == 1) ? busy1 : busy2);
  endfunction

  function automatic logic empty_of(input int sel);
    return (sel == 0) ? if0.empty : ((sel == 1) ? if1.empty : if2.empty);
  endfunction

  // One-edge push; returns at the sample just after the push edge.
  task automatic push(input int sel, input logic [7:0] d);
    set_wr(sel, 1'b1, d);
    tick();
    set_wr(sel, 1'b0, 8'h00);
  endtask

  // Mid-bit reader on dut0's line; t0 is the cycle at which the start bit was first seen low.
  task automatic rx_byte(output logic [7:0] d, output int t0, output bit ok);
    int n;
    n  = 0;
    d  = '0;
    t0 = 0;
    ok = 1'b0;
    tick();
    while (tx0 !== 1'b0 && n < 600) begin
      tick();
      n++;
    end
    if (tx0 !== 1'b0) return;
    t0 = cyc;
    repeat (BD / 2) tick();
    ok = (tx0 === 1'b0);
    for (int k = 0; k < 8; k++) begin
      repeat (BD) tick();
      d[k] = tx0;
    end
    repeat (BD) tick();
    ok = ok && (tx0 === 1'b1);
  endtask

  vec_t vecs[8];
  logic [7:0] rd [5];
  int         ts [5];
  bit         rok[5];

  initial begin
    bit level_ok;
    bit line_ok;
    logic prev_busy;
    int sel;

    vecs[0] = '{0, 8'h55, 10, 11'b01010101010};
    vecs[1] = '{0, 8'h00, 10, 11'b01000000000};
    vecs[2] = '{0, 8'hFF, 10, 11'b01111111110};
    vecs[3] = '{0, 8'h80, 10, 11'b01100000000};
    vecs[4] = '{1, 8'h07, 11, 11'b11000001110};
    vecs[5] = '{2, 8'h07, 11, 11'b10000001110};
    vecs[6] = '{1, 8'h03, 11, 11'b10000000110};
    vecs[7] = '{2, 8'h03, 11, 11'b11000000110};

    rst = 1'b1;
    for (int s = 0; s < 3; s++) set_wr(s, 1'b0, 8'h00);
    repeat (5) tick();
    rst = 1'b0;
    tick();
    check("rst_tx", tx0, 1);
    check("rst_empty", if0.empty, 1);
    check("rst_busy", busy0, 0);
    check("rst_full", if0.full, 0);
    check("rst_overflow", if0.overflow, 0);
    line_ok = 1'b1;
    for (int c = 0; c < 100; c++) begin
      tick();
      if (tx0 !== 1'b1 || tx1 !== 1'b1 || tx2 !== 1'b1) line_ok = 1'b0;
    end
    check("idle_line_high", line_ok, 1);

    // Single frames: latency, per-level value and duration, exact frame length
    for (int v = 0; v < 8; v++) begin
      sel = vecs[v].sel;
      push(sel, vecs[v].data);
      check($sformatf("v%0d_tx_at_push_edge", v), tx_of(sel), 1);
      tick();
      check($sformatf("v%0d_busy_after_pop", v), {tx_of(sel), busy_of(sel)}, 2'b11);
      prev_busy = 1'b0;
      for (int i = 0; i < vecs[v].nbits; i++) begin
        level_ok = 1'b1;
        for (int c = 0; c < BD; c++) begin
          prev_busy = busy_of(sel);
          tick();
          if (tx_of(sel) !== vecs[v].exp_line[i]) level_ok = 1'b0;
        end
        check($sformatf("v%0d_level%0d", v, i), level_ok, 1);
      end
      check($sformatf("v%0d_busy_end", v), {prev_busy, busy_of(sel)}, 2'b10);
      check($sformatf("v%0d_empty_end", v), empty_of(sel), 1);
      repeat (3) tick();
    end

    // Three queued bytes leave as contiguous frames
    fork
      begin
        push(0, 8'hA5);
        push(0, 8'h3C);
        push(0, 8'hFF);
      end
      begin
        for (int k = 0; k < 3; k++) rx_byte(rd[k], ts[k], rok[k]);
      end
    join
    check("b2b_byte0", {rok[0], rd[0]}, {1'b1, 8'hA5});
    check("b2b_byte1", {rok[1], rd[1]}, {1'b1, 8'h3C});
    check("b2b_byte2", {rok[2], rd[2]}, {1'b1, 8'hFF});
    check("b2b_gap01", ts[1] - ts[0], 10 * BD);
    check("b2b_gap12", ts[2] - ts[1], 10 * BD);
    repeat (20) tick();

    // Fill to full while the first frame starts, then overflow one byte
    fork
      begin
        for (int j = 0; j < 5; j++) begin
          push(0, 8'h11 + 8'(j));
          if (j == 3) check("not_full_after_4", if0.full, 0);
          if (j == 4) check("full_after_5", if0.full, 1);
        end
        set_wr(0, 1'b1, 8'h99);
        tick();
        set_wr(0, 1'b0, 8'h00);
        check("overflow_pulse", {if0.overflow, if0.full}, 2'b11);
        tick();
        check("overflow_cleared", if0.overflow, 0);
      end
      begin
        for (int k = 0; k < 5; k++) rx_byte(rd[k], ts[k], rok[k]);
      end
    join
    for (int k = 0; k < 5; k++)
      check($sformatf("fill_byte%0d", k), {rok[k], rd[k]}, {1'b1, 8'h11 + 8'(k)});
    line_ok = 1'b1;
    for (int c = 0; c < 400; c++) begin
      tick();
      if (tx0 !== 1'b1) line_ok = 1'b0;
    end
    check("dropped_byte_not_sent", {line_ok, if0.empty}, 2'b11);

    // Reset during bit 3 of the first of two queued frames
    push(0, 8'h0F);
    push(0, 8'h10);
    repeat (70) tick();
    check("pre_rst_busy", busy0, 1);
    rst = 1'b1;
    tick();
    check("midframe_rst_tx", tx0, 1);
    check("midframe_rst_empty", if0.empty, 1);
    check("midframe_rst_busy", busy0, 0);
    rst = 1'b0;
    line_ok = 1'b1;
    for (int c = 0; c < 400; c++) begin
      tick();
      if (tx0 !== 1'b1) line_ok = 1'b0;
    end
    check("no_tx_after_rst", line_ok, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end
endmodule
